// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cache_pkg
// Brief    : Shared types and helpers for the data-cache miss handler.
//            Holds the default cache geometry, the miss-handler state
//            encoding and the {tag, set} address pack/unpack helpers.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int C_SETS      = 4;
    localparam int C_WAYS      = 4;
    localparam int C_TAG_BITS  = 6;
    localparam int C_DATA_BITS = 8;
    localparam int C_SET_BITS  = $clog2(C_SETS);
    localparam int C_ADDR_BITS = C_TAG_BITS + C_SET_BITS;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECT    = 3'd1,
        WRITEBACK = 3'd2,
        FETCH     = 3'd3,
        FILL      = 3'd4
    } mh_state_t;

    // Line address is the tag on top of the set index.
    function automatic logic [C_ADDR_BITS-1:0] cache_addr(
        input logic [C_TAG_BITS-1:0] tag,
        input logic [C_SET_BITS-1:0] set
    );
        return {tag, set};
    endfunction

    function automatic logic [C_TAG_BITS-1:0] cache_addr_tag(input logic [C_ADDR_BITS-1:0] addr);
        return addr[C_ADDR_BITS-1:C_SET_BITS];
    endfunction

    function automatic logic [C_SET_BITS-1:0] cache_addr_set(input logic [C_ADDR_BITS-1:0] addr);
        return addr[C_SET_BITS-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_miss_handler_invalid_way_finder.sv
`default_nettype none
// ============================================================================
// Module   : invalid_way_finder
// Brief    : Combinational priority encoder returning the lowest-index way
//            whose valid bit is clear, plus a flag saying one exists.
// Revision : 1.0 - initial release
// ============================================================================
module invalid_way_finder
    import cache_pkg::*;
#(
    parameter int WAYS     = C_WAYS,
    parameter int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]     valid,
    output logic                found,
    output logic [WAY_BITS-1:0] way
);

    // Scan from the top down so the lowest invalid index is the last writer.
    always_comb begin
        found = 1'b0;
        way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                found = 1'b1;
                way   = i[WAY_BITS-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_miss_handler.sv
`default_nettype none
// ============================================================================
// Module   : cache_miss_handler
// Brief    : Single-outstanding miss handler for the per-core data cache.
//            Picks a victim way, writes back a dirty victim, fetches the
//            missing word and issues one fill write to the tag/data arrays.
//            Optional build macro CACHE_MH_INVALID_FIRST_EN: prefer the
//            lowest invalid way and only consult round-robin on a full set.
// Revision : 1.0 - initial release
// ============================================================================
module cache_miss_handler
    import cache_pkg::*;
#(
    parameter int SETS      = C_SETS,
    parameter int WAYS      = C_WAYS,
    parameter int TAG_BITS  = C_TAG_BITS,
    parameter int DATA_BITS = C_DATA_BITS,
    parameter int SET_BITS  = (SETS > 1) ? $clog2(SETS) : 1,
    parameter int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1,
    parameter int ADDR_BITS = TAG_BITS + SET_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 miss_valid,
    output logic                 miss_ready,
    input  logic [SET_BITS-1:0]  miss_set,
    input  logic [TAG_BITS-1:0]  miss_tag,
    output logic [SET_BITS-1:0]  rr_set_idx,
    output logic                 rr_evict_req,
    input  logic [WAY_BITS-1:0]  rr_victim_way,
    input  logic [WAYS-1:0]      set_valid,
    input  logic [WAYS-1:0]      set_dirty,
    input  logic [TAG_BITS-1:0]  victim_tag,
    input  logic [DATA_BITS-1:0] victim_data,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic                 fill_valid,
    output logic [WAY_BITS-1:0]  fill_way,
    output logic [TAG_BITS-1:0]  fill_tag,
    output logic [DATA_BITS-1:0] fill_data
);

    mh_state_t r_state;
    mh_state_t w_next_state;

    logic [SET_BITS-1:0]  r_set;
    logic [TAG_BITS-1:0]  r_tag;
    logic [WAY_BITS-1:0]  r_way;
    logic [TAG_BITS-1:0]  r_vtag;
    logic [DATA_BITS-1:0] r_vdata;
    logic [DATA_BITS-1:0] r_rdata;

    logic [WAY_BITS-1:0]  w_rr_way;
    logic [WAY_BITS-1:0]  w_sel_way;
    logic                 w_use_rr;
    logic                 w_victim_dirty;

    // A single-way cache has only way 0, whatever the pointer says.
    generate
        if (WAYS == 1) begin : g_single_way
            assign w_rr_way = '0;
        end else begin : g_multi_way
            assign w_rr_way = rr_victim_way;
        end
    endgenerate

`ifdef CACHE_MH_INVALID_FIRST_EN
    logic                w_inv_found;
    logic [WAY_BITS-1:0] w_inv_way;

    invalid_way_finder #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_invalid_way_finder (
        .valid (set_valid),
        .found (w_inv_found),
        .way   (w_inv_way)
    );

    // An empty slot beats eviction; the RR pointer only moves on a full set.
    assign w_use_rr  = !w_inv_found;
    assign w_sel_way = w_inv_found ? w_inv_way : w_rr_way;
`else
    assign w_use_rr  = 1'b1;
    assign w_sel_way = w_rr_way;
`endif

    assign w_victim_dirty = set_valid[w_sel_way] && set_dirty[w_sel_way];

    // During SELECT the arrays are read at the way being chosen right now,
    // so victim_tag/victim_data are valid at the edge that registers them.
    assign fill_way          = (r_state == SELECT) ? w_sel_way : r_way;
    assign miss_ready        = (r_state == IDLE);
    assign rr_set_idx        = r_set;
    assign mem_write_valid   = (r_state == WRITEBACK);
    assign mem_write_address = {r_vtag, r_set};
    assign mem_write_data    = r_vdata;
    assign mem_read_valid    = (r_state == FETCH);
    assign mem_read_address  = {r_tag, r_set};
    assign fill_valid        = (r_state == FILL);
    assign fill_tag          = r_tag;
    assign fill_data         = r_rdata;

    // State register; reset aborts any miss in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and the replacement-pointer bump strobe.
    always_comb begin
        w_next_state = r_state;
        rr_evict_req = 1'b0;
        case (r_state)
            IDLE: begin
                if (miss_valid) begin
                    w_next_state = SELECT;
                end
            end
            SELECT: begin
                rr_evict_req = w_use_rr;
                w_next_state = w_victim_dirty ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                if (mem_write_ready) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                if (mem_read_ready) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the request, the victim snapshot and the returned word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_set   <= '0;
            r_tag   <= '0;
            r_way   <= '0;
            r_vtag  <= '0;
            r_vdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_valid) begin
                        r_set <= miss_set;
                        r_tag <= miss_tag;
                    end
                end
                SELECT: begin
                    r_way   <= w_sel_way;
                    r_vtag  <= victim_tag;
                    r_vdata <= victim_data;
                end
                FETCH: begin
                    if (mem_read_ready) begin
                        r_rdata <= mem_read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_miss_handler
// Brief    : Self-checking bench for cache_miss_handler with a tag-array,
//            round-robin and memory environment plus a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_miss_handler;
    import cache_pkg::*;

    localparam int SETS      = 4;
    localparam int WAYS      = 4;
    localparam int TAG_BITS  = 6;
    localparam int DATA_BITS = 8;
    localparam int SET_BITS  = 2;
    localparam int WAY_BITS  = 2;
    localparam int ADDR_BITS = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 miss_valid = 1'b0;
    logic                 miss_ready;
    logic [SET_BITS-1:0]  miss_set = '0;
    logic [TAG_BITS-1:0]  miss_tag = '0;
    logic [SET_BITS-1:0]  rr_set_idx;
    logic                 rr_evict_req;
    logic [WAY_BITS-1:0]  rr_victim_way;
    logic [WAYS-1:0]      set_valid;
    logic [WAYS-1:0]      set_dirty;
    logic [TAG_BITS-1:0]  victim_tag;
    logic [DATA_BITS-1:0] victim_data;
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;
    logic                 fill_valid;
    logic [WAY_BITS-1:0]  fill_way;
    logic [TAG_BITS-1:0]  fill_tag;
    logic [DATA_BITS-1:0] fill_data;

    always #5 clk = ~clk;

    cache_miss_handler dut (
        .clk               (clk),
        .reset             (reset),
        .miss_valid        (miss_valid),
        .miss_ready        (miss_ready),
        .miss_set          (miss_set),
        .miss_tag          (miss_tag),
        .rr_set_idx        (rr_set_idx),
        .rr_evict_req      (rr_evict_req),
        .rr_victim_way     (rr_victim_way),
        .set_valid         (set_valid),
        .set_dirty         (set_dirty),
        .victim_tag        (victim_tag),
        .victim_data       (victim_data),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready),
        .fill_valid        (fill_valid),
        .fill_way          (fill_way),
        .fill_tag          (fill_tag),
        .fill_data         (fill_data)
    );

    // ---------------- environment: arrays, RR pointers, memory ----------------
    logic                 tv    [SETS][WAYS];
    logic                 td    [SETS][WAYS];
    logic [TAG_BITS-1:0]  ttag  [SETS][WAYS];
    logic [DATA_BITS-1:0] tdata [SETS][WAYS];
    logic [WAY_BITS-1:0]  rr_ptr[SETS];

    int rd_cnt = 0, wr_cnt = 0, rd_delay = 0, wr_delay = 0;

    logic       cfg_req = 1'b0;
    int         cfg_set = 0, cfg_ptr = 0, cfg_tag = 0;
    logic [3:0] cfg_valid = '0, cfg_dirty = '0;

    always_comb begin
        set_valid = '0;
        set_dirty = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = tv[rr_set_idx][w];
            set_dirty[w] = td[rr_set_idx][w];
        end
    end

    assign victim_tag      = ttag[rr_set_idx][fill_way];
    assign victim_data     = tdata[rr_set_idx][fill_way];
    assign rr_victim_way   = rr_ptr[rr_set_idx];
    assign mem_read_data   = mem_read_address ^ 8'h3C;
    assign mem_read_ready  = mem_read_valid && (rd_cnt >= rd_delay);
    assign mem_write_ready = mem_write_valid && (wr_cnt >= wr_delay);

    always @(posedge clk) begin
        rd_cnt <= (mem_read_valid && !mem_read_ready) ? rd_cnt + 1 : 0;
        wr_cnt <= (mem_write_valid && !mem_write_ready) ? wr_cnt + 1 : 0;
        if (rr_evict_req) rr_ptr[rr_set_idx] <= rr_ptr[rr_set_idx] + 1'b1;
        if (fill_valid) begin
            tv[rr_set_idx][fill_way]    <= 1'b1;
            td[rr_set_idx][fill_way]    <= 1'b0;
            ttag[rr_set_idx][fill_way]  <= fill_tag;
            tdata[rr_set_idx][fill_way] <= fill_data;
        end
        if (cfg_req) begin
            for (int w = 0; w < WAYS; w++) begin
                tv[cfg_set][w]    <= cfg_valid[w];
                td[cfg_set][w]    <= cfg_dirty[w];
                ttag[cfg_set][w]  <= TAG_BITS'(cfg_tag + w);
                tdata[cfg_set][w] <= DATA_BITS'(16 * cfg_set + w);
            end
            rr_ptr[cfg_set] <= WAY_BITS'(cfg_ptr);
        end
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0, n_err = 0;
    int n_evicts = 0, txn_evicts = 0, rd_cycles = 0;
    int last_waddr = -1, last_wdata = -1, last_raddr = -1, last_fill_way = -1;
    int exp_set, exp_tag, exp_way, exp_waddr, exp_wdata, exp_raddr, exp_rdata;
    bit exp_wb, exp_evict;
    logic busy, wb_done;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectation for a miss issued now.
    task automatic model_expect(input int s, input int t);
        int w;
        bit found;
        w = int'(rr_ptr[s]);
        found = 1'b0;
`ifdef CACHE_MH_INVALID_FIRST_EN
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !tv[s][i]) begin
                found = 1'b1;
                w = i;
            end
        end
`endif
        exp_set    = s;
        exp_tag    = t;
        exp_way    = w;
        exp_evict  = !found;
        exp_wb     = tv[s][w] && td[s][w];
        exp_waddr  = int'(cache_addr(ttag[s][w], SET_BITS'(s)));
        exp_wdata  = int'(tdata[s][w]);
        exp_raddr  = int'(cache_addr(TAG_BITS'(t), SET_BITS'(s)));
        exp_rdata  = exp_raddr ^ 8'h3C;
        txn_evicts = 0;
    endtask

    // A miss is outstanding from its acceptance edge until the fill edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            wb_done <= 1'b0;
        end else begin
            if (miss_valid && miss_ready) begin
                busy    <= 1'b1;
                wb_done <= 1'b0;
            end else if (fill_valid) begin
                busy <= 1'b0;
            end
            if (mem_write_valid && mem_write_ready) wb_done <= 1'b1;
        end
    end

    // Compare DUT outputs against the transaction model every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check(miss_ready == !busy, "miss_ready", int'(miss_ready), int'(!busy));
            if (!busy) begin
                check(!(mem_write_valid || mem_read_valid || fill_valid || rr_evict_req), "idle_quiet",
                      int'({mem_write_valid, mem_read_valid, fill_valid, rr_evict_req}), 0);
            end else begin
                if (mem_write_valid) begin
                    check(exp_wb && !wb_done, "wb_expected", 1, int'(exp_wb && !wb_done));
                    check(mem_write_address == exp_waddr, "wb_addr", int'(mem_write_address), exp_waddr);
                    check(mem_write_data == exp_wdata, "wb_data", int'(mem_write_data), exp_wdata);
                    last_waddr = int'(mem_write_address);
                    last_wdata = int'(mem_write_data);
                end
                if (mem_read_valid) begin
                    check(!exp_wb || wb_done, "rd_after_wb", int'(wb_done), 1);
                    check(mem_read_address == exp_raddr, "rd_addr", int'(mem_read_address), exp_raddr);
                    last_raddr = int'(mem_read_address);
                    rd_cycles++;
                end
                if (rr_evict_req) begin
                    check(exp_evict, "evict_allowed", 1, int'(exp_evict));
                    check(rr_set_idx == exp_set, "evict_set", int'(rr_set_idx), exp_set);
                    txn_evicts++;
                    n_evicts++;
                end
                if (fill_valid) begin
                    check(fill_way == exp_way, "fill_way", int'(fill_way), exp_way);
                    check(fill_tag == exp_tag, "fill_tag", int'(fill_tag), exp_tag);
                    check(fill_data == exp_rdata, "fill_data", int'(fill_data), exp_rdata);
                    check(rr_set_idx == exp_set, "fill_set", int'(rr_set_idx), exp_set);
                    check(txn_evicts == int'(exp_evict), "evict_count", txn_evicts, int'(exp_evict));
                    last_fill_way = int'(fill_way);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic setup_set(input int s, input logic [3:0] v, input logic [3:0] d, input int p, input int t);
        cfg_set = s; cfg_valid = v; cfg_dirty = d; cfg_ptr = p; cfg_tag = t;
        cfg_req = 1'b1;
        @(posedge clk);
        #1 cfg_req = 1'b0;
        @(negedge clk);
    endtask

    // Called just after a negedge; returns at the negedge miss_ready is back.
    task automatic do_miss(input int s, input int t, output int lat);
        int k;
        k = 0;
        while (!miss_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(miss_ready, "accept_wait", int'(miss_ready), 1);
        model_expect(s, t);
        miss_valid = 1'b1;
        miss_set   = SET_BITS'(s);
        miss_tag   = TAG_BITS'(t);
        @(posedge clk);
        #1 miss_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!miss_ready && lat < 200);
        check(lat < 200, "miss_timeout", lat, 199);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, e0, r0, k;
        int exp_seq[5] = '{0, 1, 2, 3, 0};

        repeat (2) @(negedge clk);
        for (int s = 0; s < SETS; s++) setup_set(s, 4'h0, 4'h0, 0, 0);

        // Reset state
        check(miss_ready == 1'b1, "rst_miss_ready", int'(miss_ready), 1);
        check(mem_read_valid == 1'b0, "rst_rd_valid", int'(mem_read_valid), 0);
        check(mem_write_valid == 1'b0, "rst_wr_valid", int'(mem_write_valid), 0);
        check(fill_valid == 1'b0, "rst_fill_valid", int'(fill_valid), 0);
        check(rr_evict_req == 1'b0, "rst_evict", int'(rr_evict_req), 0);
        check(mem_read_address == 8'h00, "rst_rd_addr", int'(mem_read_address), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Clean miss, full set, RR pointer at 2
        setup_set(0, 4'hF, 4'h0, 2, 0);
        e0 = n_evicts;
        do_miss(0, 'h2A, lat);
        check(lat == 4, "clean_latency", lat, 4);
        check(n_evicts - e0 == 1, "clean_evicts", n_evicts - e0, 1);
        check(last_fill_way == 2, "clean_way", last_fill_way, 2);
        check(last_raddr == 'hA8, "clean_rd_addr", last_raddr, 'hA8);
        check(tdata[0][2] == 8'h94, "clean_fill_data", int'(tdata[0][2]), 'h94);

        // Dirty victim: tag 0x15 in set 1 written back to 0x55 first
        setup_set(1, 4'hF, 4'b0010, 1, 'h14);
        wr_delay = 2;
        do_miss(1, 'h03, lat);
        wr_delay = 0;
        check(last_waddr == 'h55, "dirty_wb_addr", last_waddr, 'h55);
        check(last_wdata == 'h11, "dirty_wb_data", last_wdata, 'h11);
        check(last_fill_way == 1, "dirty_way", last_fill_way, 1);
        check(last_raddr == 'h0D, "dirty_rd_addr", last_raddr, 'h0D);

        // Slow memory read: request held six cycles
        setup_set(2, 4'hF, 4'h0, 3, 'h20);
        rd_delay = 5;
        r0 = rd_cycles;
        do_miss(2, 'h3F, lat);
        rd_delay = 0;
        check(rd_cycles - r0 == 6, "slow_rd_cycles", rd_cycles - r0, 6);
        check(lat == 9, "slow_latency", lat, 9);
        check(last_fill_way == 3, "slow_way", last_fill_way, 3);

        // Partially valid set 1011
        setup_set(2, 4'b1011, 4'h0, 0, 'h20);
        e0 = n_evicts;
        do_miss(2, 'h01, lat);
`ifdef CACHE_MH_INVALID_FIRST_EN
        check(last_fill_way == 2, "inv_first_way", last_fill_way, 2);
        check(n_evicts - e0 == 0, "inv_first_evicts", n_evicts - e0, 0);
`else
        check(last_fill_way == 0, "rr_only_way", last_fill_way, 0);
        check(n_evicts - e0 == 1, "rr_only_evicts", n_evicts - e0, 1);
`endif

        // Reset while writing back a dirty victim
        setup_set(1, 4'hF, 4'b0100, 2, 'h30);
        wr_delay = 20;
        e0 = n_evicts;
        model_expect(1, 'h05);
        miss_valid = 1'b1;
        miss_set   = 2'd1;
        miss_tag   = 6'h05;
        @(posedge clk);
        #1 miss_valid = 1'b0;
        k = 0;
        while (!mem_write_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check(mem_write_valid == 1'b1, "abort_wb_reached", int'(mem_write_valid), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check(miss_ready == 1'b1, "abort_miss_ready", int'(miss_ready), 1);
        check(mem_write_valid == 1'b0, "abort_wr_valid", int'(mem_write_valid), 0);
        check(mem_read_valid == 1'b0, "abort_rd_valid", int'(mem_read_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        wr_delay = 0;
        @(negedge clk);
        do_miss(1, 'h06, lat);
        check(last_fill_way == 3, "after_abort_way", last_fill_way, 3);
        check(n_evicts - e0 == 2, "after_abort_evicts", n_evicts - e0, 2);

        // Back-to-back misses to set 3 walk the pointer round and wrap
        setup_set(3, 4'hF, 4'h0, 0, 'h08);
        e0 = n_evicts;
        for (int i = 0; i < 5; i++) begin
            do_miss(3, 'h10 + i, lat);
            check(last_fill_way == exp_seq[i], "b2b_way", last_fill_way, exp_seq[i]);
        end
        check(n_evicts - e0 == 5, "b2b_evicts", n_evicts - e0, 5);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
